bsg_global_buffer_tile_banked: RTL and testbench
================================================

// Module: bsg_global_buffer_tile_banked
// PURPOSE
// - Next-gen global buffer tile: num_banks_p single-port sync SRAM banks behind one RO ring hop, one WO ring hop and one local RW port.
// - RO ring: no backpressure; each hop is registered (1 cycle). WO ring: valid/ready backpressure, with a local write FIFO.
// - Per-bank priority is RO > WO > RW. An RW starvation guard lifts RW above WO. The tile sits in a row of num_tiles_x_p tiles.
// PARAMETERS
// - data_width_p        32  word width
// - bank_els_p          1024 total words per tile; must be a multiple of num_banks_p
// - num_banks_p         4   banks, power of 2 >= 1; bank = addr[lg(num_banks_p)-1:0]; row = remaining upper bits
// - num_tiles_x_p       8   ring length; x_cord_width_lp = SAFE_CLOG2(num_tiles_x_p)
// - wo_fifo_els_p       4   local WO write FIFO depth, >= 2
// - rw_starve_limit_p   8   consecutive RW-stalled cycles before RW outranks WO
// PORTS
// - clk_i          in   1   clock
// - reset_i        in   1   synchronous, active-high reset
// - my_x_i         in   xw  this tile's x coordinate
// - ro_addr_i/ro_dest_x_i/ro_addr_v_i  in   aw/xw/1  RO request from the upstream hop
// - ro_addr_o/ro_dest_x_o/ro_addr_v_o  out  aw/xw/1  RO request to the downstream hop (registered)
// - ro_data_i/ro_data_v_i  in   dw/1  RO response from the upstream hop
// - ro_data_o/ro_data_v_o  out  dw/1  RO response to the downstream hop (registered)
// - wo_addr_i/wo_dest_x_i/wo_data_i/wo_v_i  in  aw/xw/dw/1  WO request from upstream; wo_ready_o out 1
// - wo_addr_o/wo_dest_x_o/wo_data_o/wo_v_o  out aw/xw/dw/1  WO request to downstream; wo_ready_i in 1
// - rw_addr_i/rw_data_i/rw_w_i/rw_v_i  in  aw/dw/1/1  local RW request; rw_yumi_o out 1 (same-cycle accept)
// - rw_data_o/rw_data_v_o  out  dw/1  RW read data, valid 1 cycle after the yumi of a read
// - aw = SAFE_CLOG2(bank_els_p)
// BEHAVIOUR
// - Reset (sync): every *_v_o = 0, rw_yumi_o = 0, WO FIFO and forward buffer empty, starve counter = 0.
//   Data outputs are don't-care while their valid is 0.
// - RO request, dest == my_x_i: read issued to the selected bank the same cycle; ro_addr_v_o = 0 next cycle.
// - RO request, dest != my_x_i: request forwarded unchanged, 1-cycle latency.
// - RO response: local read data is sampled from the bank at t+1 and drives ro_data_o/ro_data_v_o at t+2.
//   Otherwise ro_data_i/ro_data_v_i is registered through (1 cycle).
//   Local response and ro_data_v_i in the same cycle is a protocol violation: assertion fires; the local response wins.
// - Two RO ring requests cannot target one bank in one cycle: one request per cycle enters the tile.
// - WO input, dest == my_x_i: enqueue into the local FIFO; wo_ready_o = FIFO not full.
// - WO input, dest != my_x_i: enqueue into a 2-entry forward buffer; wo_ready_o = buffer not full.
//   wo_v_o = buffer not empty; pop on wo_v_o & wo_ready_i. No combinational path from wo_ready_i to wo_ready_o.
// - Accept a WO beat on wo_v_i & wo_ready_o. wo_ready_o may depend combinationally on wo_dest_x_i.
// - Bank arbitration, per bank per cycle:
//   - RO always wins its bank.
//   - Otherwise WO FIFO head vs RW: WO wins unless starve_cnt >= rw_starve_limit_p.
//   - Requests to different banks proceed in parallel (RO, WO and RW each to a distinct bank all succeed the same cycle).
// - WO head is popped when granted. rw_yumi_o = rw_v_i & granted.
// - Starve counter: +1 each cycle rw_v_i & !rw_yumi_o, saturating at rw_starve_limit_p; cleared on rw_yumi_o or !rw_v_i.
// - A write and a read to one address in one cycle cannot both be granted (single-port bank). Read-after-write returns the new data.
// - Reset mid-operation: in-flight reads are discarded; rw_data_v_o and ro_data_v_o are 0 on the cycle after reset.
// CONFIGURATION
// - BSG_GB_TILE_PERF_EN defined: adds these outputs, cleared by reset:
//   - perf_rw_stall_o [31:0]: saturating count of rw_v_i & !rw_yumi_o cycles.
//   - perf_wo_stall_o [31:0]: saturating count of cycles the WO FIFO head is valid but not granted.
//   - perf_ro_hits_o [31:0]: saturating count of local RO reads.
// - BSG_GB_TILE_PERF_EN undefined: those ports and their counters do not exist; behaviour is otherwise identical.
// TESTING
// - Reset, then idle 5 cycles -> all *_v_o = 0, rw_yumi_o = 0, wo_ready_o = 1.
// - WO local write addr 5, data 0xA5; then RO local read addr 5 -> ro_data_o = 0xA5, ro_data_v_o = 1 exactly 2 cycles after the request.
// - RO request to dest my_x+1 at t -> ro_addr_o identical at t+1, no bank access.
//   ro_data_v_i = 1 with 0x3C at t -> ro_data_o = 0x3C at t+1.
// - RW read and RO read to bank 0 held every cycle, rw_starve_limit_p = 8 -> RO served every cycle; rw_yumi_o stays 0 (RO always wins).
// - RW and WO both to bank 1 every cycle -> WO wins 8 cycles, RW yumi on cycle 9, then the counter clears.
//   With BSG_GB_TILE_PERF_EN defined, perf_rw_stall_o = 8.
// - Hold wo_ready_i = 0; send 3 non-local WO beats -> beats 1-2 accepted, wo_ready_o = 0 for beat 3.
//   Release wo_ready_i -> beats emerge in order. Then 4 local beats -> FIFO full, wo_ready_o = 0.

Source files
------------

// File: rtl/bsg_global_buffer_tile_banked_if.sv
// Ring/port bundle for bsg_global_buffer_tile_banked: RO ring hop, WO ring hop and local RW port.
// slave = the tile side, master = the surrounding fabric / bench side.
interface bsg_global_buffer_tile_banked_if #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 10,
    parameter int x_cord_width_p = 3
);
    logic [addr_width_p-1:0]   ro_addr_i, ro_addr_o;
    logic [x_cord_width_p-1:0] ro_dest_x_i, ro_dest_x_o;
    logic                      ro_addr_v_i, ro_addr_v_o;
    logic [data_width_p-1:0]   ro_data_i, ro_data_o;
    logic                      ro_data_v_i, ro_data_v_o;

    logic [addr_width_p-1:0]   wo_addr_i, wo_addr_o;
    logic [x_cord_width_p-1:0] wo_dest_x_i, wo_dest_x_o;
    logic [data_width_p-1:0]   wo_data_i, wo_data_o;
    logic                      wo_v_i, wo_ready_o, wo_v_o, wo_ready_i;

    logic [addr_width_p-1:0]   rw_addr_i;
    logic [data_width_p-1:0]   rw_data_i, rw_data_o;
    logic                      rw_w_i, rw_v_i, rw_yumi_o, rw_data_v_o;

    modport slave (
        input  ro_addr_i, ro_dest_x_i, ro_addr_v_i, ro_data_i, ro_data_v_i,
        output ro_addr_o, ro_dest_x_o, ro_addr_v_o, ro_data_o, ro_data_v_o,
        input  wo_addr_i, wo_dest_x_i, wo_data_i, wo_v_i, wo_ready_i,
        output wo_ready_o, wo_addr_o, wo_dest_x_o, wo_data_o, wo_v_o,
        input  rw_addr_i, rw_data_i, rw_w_i, rw_v_i,
        output rw_yumi_o, rw_data_o, rw_data_v_o
    );

    modport master (
        output ro_addr_i, ro_dest_x_i, ro_addr_v_i, ro_data_i, ro_data_v_i,
        input  ro_addr_o, ro_dest_x_o, ro_addr_v_o, ro_data_o, ro_data_v_o,
        output wo_addr_i, wo_dest_x_i, wo_data_i, wo_v_i, wo_ready_i,
        input  wo_ready_o, wo_addr_o, wo_dest_x_o, wo_data_o, wo_v_o,
        output rw_addr_i, rw_data_i, rw_w_i, rw_v_i,
        input  rw_yumi_o, rw_data_o, rw_data_v_o
    );
endinterface

// File: rtl/bsg_global_buffer_tile_banked.sv
// Banked global-buffer tile: RO ring hop, WO ring hop with local write FIFO, local RW port.
// Optional perf counters are enabled by defining BSG_GB_TILE_PERF_EN.
module bsg_global_buffer_tile_banked #(
    parameter int data_width_p      = 32,
    parameter int bank_els_p        = 1024,
    parameter int num_banks_p       = 4,
    parameter int num_tiles_x_p     = 8,
    parameter int wo_fifo_els_p     = 4,
    parameter int rw_starve_limit_p = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic [((num_tiles_x_p > 1) ? $clog2(num_tiles_x_p) : 1)-1:0] my_x_i,
    bsg_global_buffer_tile_banked_if.slave io
`ifdef BSG_GB_TILE_PERF_EN
    ,
    output logic [31:0] perf_rw_stall_o,
    output logic [31:0] perf_wo_stall_o,
    output logic [31:0] perf_ro_hits_o
`endif
);
    localparam int x_cord_width_lp = (num_tiles_x_p > 1) ? $clog2(num_tiles_x_p) : 1;
    localparam int addr_width_lp   = (bank_els_p > 1) ? $clog2(bank_els_p) : 1;
    localparam int lg_banks_lp     = (num_banks_p > 1) ? $clog2(num_banks_p) : 0;
    localparam int bank_w_lp       = (num_banks_p > 1) ? lg_banks_lp : 1;
    localparam int rows_lp         = bank_els_p / num_banks_p;
    localparam int row_w_lp        = (rows_lp > 1) ? $clog2(rows_lp) : 1;
    localparam int fifo_ptr_w_lp   = (wo_fifo_els_p > 1) ? $clog2(wo_fifo_els_p) : 1;
    localparam int fifo_cnt_w_lp   = $clog2(wo_fifo_els_p + 1);
    localparam int starve_w_lp     = $clog2(rw_starve_limit_p + 1);

    typedef struct packed {
        logic [x_cord_width_lp-1:0] dest;
        logic [addr_width_lp-1:0]   addr;
        logic [data_width_p-1:0]    data;
    } wo_beat_t;

    function automatic logic [bank_w_lp-1:0] bank_of(input logic [addr_width_lp-1:0] a);
        return bank_w_lp'(a % addr_width_lp'(num_banks_p));
    endfunction

    function automatic logic [row_w_lp-1:0] row_of(input logic [addr_width_lp-1:0] a);
        return row_w_lp'(a >> lg_banks_lp);
    endfunction

    function automatic logic [fifo_ptr_w_lp-1:0] ptr_inc(input logic [fifo_ptr_w_lp-1:0] p);
        return (p == fifo_ptr_w_lp'(wo_fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- RO ring hop ----------------
    logic                 ro_local, ro_rd_pending, rw_rd_pending;
    logic [bank_w_lp-1:0] ro_bank, rw_bank, wo_bank, ro_rd_bank_r, rw_rd_bank_r;
    logic [num_banks_p-1:0][data_width_p-1:0] bank_dout;

    assign ro_local = io.ro_addr_v_i && (io.ro_dest_x_i == my_x_i);
    assign ro_bank  = bank_of(io.ro_addr_i);
    assign rw_bank  = bank_of(io.rw_addr_i);

    logic rw_gnt;

    always_ff @(posedge clk_i) begin
        io.ro_addr_o   <= io.ro_addr_i;
        io.ro_dest_x_o <= io.ro_dest_x_i;
        ro_rd_bank_r   <= ro_bank;
        rw_rd_bank_r   <= rw_bank;
        // A local read response owns the output slot over the upstream ring data.
        io.ro_data_o   <= ro_rd_pending ? bank_dout[ro_rd_bank_r] : io.ro_data_i;
        if (reset_i) begin
            io.ro_addr_v_o <= 1'b0;
            io.ro_data_v_o <= 1'b0;
            ro_rd_pending  <= 1'b0;
            rw_rd_pending  <= 1'b0;
        end else begin
            io.ro_addr_v_o <= io.ro_addr_v_i && !ro_local;
            io.ro_data_v_o <= ro_rd_pending || io.ro_data_v_i;
            ro_rd_pending  <= ro_local;
            rw_rd_pending  <= rw_gnt && !io.rw_w_i;
        end
    end

    assign io.rw_data_o   = bank_dout[rw_rd_bank_r];
    assign io.rw_data_v_o = rw_rd_pending;

    assert property (@(posedge clk_i) disable iff (reset_i) !(ro_rd_pending && io.ro_data_v_i));

    // ---------------- WO input steering ----------------
    logic     wo_is_local, fifo_full, fwd_full, wo_acc, fifo_push, fwd_push, fwd_pop, wo_gnt;
    wo_beat_t in_beat;

    assign in_beat       = {io.wo_dest_x_i, io.wo_addr_i, io.wo_data_i};
    assign wo_is_local   = (io.wo_dest_x_i == my_x_i);
    assign io.wo_ready_o = !reset_i && (wo_is_local ? !fifo_full : !fwd_full);
    assign wo_acc        = io.wo_v_i && io.wo_ready_o;
    assign fifo_push     = wo_acc && wo_is_local;
    assign fwd_push      = wo_acc && !wo_is_local;

    // ---------------- local WO FIFO ----------------
    wo_beat_t                 fifo_mem [wo_fifo_els_p];
    wo_beat_t                 wo_head;
    logic [fifo_ptr_w_lp-1:0] fifo_rd, fifo_wr;
    logic [fifo_cnt_w_lp-1:0] fifo_cnt;
    logic                     wo_head_v;

    assign fifo_full = (fifo_cnt == fifo_cnt_w_lp'(wo_fifo_els_p));
    assign wo_head   = fifo_mem[fifo_rd];
    assign wo_head_v = !reset_i && (fifo_cnt != '0);
    assign wo_bank   = bank_of(wo_head.addr);

    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem[fifo_wr] <= in_beat;
        if (reset_i) begin
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) fifo_wr <= ptr_inc(fifo_wr);
            if (wo_gnt)    fifo_rd <= ptr_inc(fifo_rd);
            fifo_cnt <= fifo_cnt + fifo_cnt_w_lp'(fifo_push) - fifo_cnt_w_lp'(wo_gnt);
        end
    end

    // ---------------- 2-entry forward buffer ----------------
    // Ready comes from the registered count only, so wo_ready_i never reaches wo_ready_o.
    wo_beat_t   fwd_mem [2];
    logic       fwd_rd, fwd_wr;
    logic [1:0] fwd_cnt;

    assign fwd_full = (fwd_cnt == 2'd2);
    assign io.wo_v_o = (fwd_cnt != 2'd0);
    assign {io.wo_dest_x_o, io.wo_addr_o, io.wo_data_o} = fwd_mem[fwd_rd];
    assign fwd_pop = io.wo_v_o && io.wo_ready_i;

    always_ff @(posedge clk_i) begin
        if (fwd_push) fwd_mem[fwd_wr] <= in_beat;
        if (reset_i) begin
            fwd_rd  <= 1'b0;
            fwd_wr  <= 1'b0;
            fwd_cnt <= 2'd0;
        end else begin
            if (fwd_push) fwd_wr <= !fwd_wr;
            if (fwd_pop)  fwd_rd <= !fwd_rd;
            fwd_cnt <= fwd_cnt + 2'(fwd_push) - 2'(fwd_pop);
        end
    end

    // ---------------- bank arbitration ----------------
    logic [starve_w_lp-1:0] starve_cnt;
    logic                   rw_prio, same_bank;

    assign rw_prio   = (starve_cnt >= starve_w_lp'(rw_starve_limit_p));
    assign same_bank = (wo_bank == rw_bank);
    // RO takes its bank outright; WO vs RW only matters when they share a bank.
    assign wo_gnt = wo_head_v && !(ro_local && ro_bank == wo_bank)
                 && !(io.rw_v_i && same_bank && rw_prio);
    assign rw_gnt = !reset_i && io.rw_v_i && !(ro_local && ro_bank == rw_bank)
                 && !(wo_head_v && same_bank && !rw_prio);
    assign io.rw_yumi_o = rw_gnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || !io.rw_v_i || rw_gnt) starve_cnt <= '0;
        else if (!rw_prio)                   starve_cnt <= starve_cnt + 1'b1;
    end

    // ---------------- banks ----------------
    for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
        logic [data_width_p-1:0] mem [rows_lp];
        logic [data_width_p-1:0] dout;
        logic                    ro_hit, wo_hit, rw_hit;

        assign ro_hit = ro_local && (ro_bank == bank_w_lp'(b));
        assign wo_hit = wo_gnt && (wo_bank == bank_w_lp'(b));
        assign rw_hit = rw_gnt && (rw_bank == bank_w_lp'(b));
        assign bank_dout[b] = dout;

        always_ff @(posedge clk_i) begin
            if (ro_hit)      dout <= mem[row_of(io.ro_addr_i)];
            else if (wo_hit) mem[row_of(wo_head.addr)] <= wo_head.data;
            else if (rw_hit) begin
                if (io.rw_w_i) mem[row_of(io.rw_addr_i)] <= io.rw_data_i;
                else           dout <= mem[row_of(io.rw_addr_i)];
            end
        end
    end

`ifdef BSG_GB_TILE_PERF_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_rw_stall_o <= '0;
            perf_wo_stall_o <= '0;
            perf_ro_hits_o  <= '0;
        end else begin
            if (io.rw_v_i && !rw_gnt && !(&perf_rw_stall_o)) perf_rw_stall_o <= perf_rw_stall_o + 1'b1;
            if (wo_head_v && !wo_gnt && !(&perf_wo_stall_o)) perf_wo_stall_o <= perf_wo_stall_o + 1'b1;
            if (ro_local && !(&perf_ro_hits_o))               perf_ro_hits_o  <= perf_ro_hits_o + 1'b1;
        end
    end
`else
    // Perf counters compiled out.
`endif

endmodule

// File: tb/tb_bsg_global_buffer_tile_banked.sv
// Bench for bsg_global_buffer_tile_banked: directed cases plus randomized traffic against a queue/array model.
module tb_bsg_global_buffer_tile_banked;
    localparam int DW = 32, ELS = 1024, NB = 4, NX = 8, FD = 4, LIM = 8, AW = 10, XW = 3;
    localparam logic [XW-1:0] MY_X = 3'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bsg_global_buffer_tile_banked_if #(.data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW)) bus ();

`ifdef BSG_GB_TILE_PERF_EN
    logic [31:0] perf_rw, perf_wo, perf_ro;
`endif

    bsg_global_buffer_tile_banked #(
        .data_width_p(DW), .bank_els_p(ELS), .num_banks_p(NB), .num_tiles_x_p(NX),
        .wo_fifo_els_p(FD), .rw_starve_limit_p(LIM)
    ) dut (
        .clk_i(clk), .reset_i(reset), .my_x_i(MY_X), .io(bus)
`ifdef BSG_GB_TILE_PERF_EN
        , .perf_rw_stall_o(perf_rw), .perf_wo_stall_o(perf_wo), .perf_ro_hits_o(perf_ro)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [XW-1:0] dest;
        logic [DW-1:0] data;
    } beat_t;

    logic [DW-1:0] mem [ELS];
    beat_t         fifo_q[$];
    beat_t         fwd_q[$];
    int            starve;
    bit            st1_v;
    logic [DW-1:0] st1_d;
    bit            e_roa_v, e_rod_v, e_rw_v;
    logic [AW-1:0] e_roa;
    logic [XW-1:0] e_rodest;
    logic [DW-1:0] e_rodata, e_rw_d;
    int            checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        fifo_q.delete();
        fwd_q.delete();
        starve = 0;
        st1_v = 0;
        e_roa_v = 0;
        e_rod_v = 0;
        e_rw_v = 0;
    endtask

    task automatic idle();
        bus.ro_addr_v_i = 0; bus.ro_addr_i = '0; bus.ro_dest_x_i = '0;
        bus.ro_data_v_i = 0; bus.ro_data_i = '0;
        bus.wo_v_i = 0; bus.wo_addr_i = '0; bus.wo_dest_x_i = '0; bus.wo_data_i = '0;
        bus.rw_v_i = 0; bus.rw_w_i = 0; bus.rw_addr_i = '0; bus.rw_data_i = '0;
    endtask

    // Called just after a negedge with inputs already set; checks, advances the model, returns at next negedge.
    task automatic step();
        int  own [NB];   // 0 free, 1 RO, 2 WO, 3 RW
        int  rob, rwb, wob;
        bit  ro_loc, wo_loc, rdy, yumi, wo_win;
        logic [DW-1:0] rd_ro, rd_rw;
        beat_t nb;
        #1;
        if (reset) begin
            chk("yumi_in_reset", bus.rw_yumi_o, 0);
            model_clear();
            @(negedge clk);
            return;
        end
        ro_loc = bus.ro_addr_v_i && (bus.ro_dest_x_i == MY_X);
        wo_loc = (bus.wo_dest_x_i == MY_X);
        rdy    = wo_loc ? (fifo_q.size() < FD) : (fwd_q.size() < 2);
        for (int b = 0; b < NB; b++) own[b] = 0;
        rob = int'(bus.ro_addr_i) % NB;
        rwb = int'(bus.rw_addr_i) % NB;
        wob = (fifo_q.size() > 0) ? int'(fifo_q[0].addr) % NB : 0;
        if (ro_loc) own[rob] = 1;
        if (fifo_q.size() > 0 && own[wob] == 0) own[wob] = 2;
        if (bus.rw_v_i) begin
            if (own[rwb] == 0) own[rwb] = 3;
            else if (own[rwb] == 2 && starve >= LIM) own[rwb] = 3;
        end
        yumi   = bus.rw_v_i && own[rwb] == 3;
        wo_win = fifo_q.size() > 0 && own[wob] == 2;

        chk("rw_yumi", bus.rw_yumi_o, yumi);
        chk("wo_ready", bus.wo_ready_o, rdy);
        chk("ro_addr_v", bus.ro_addr_v_o, e_roa_v);
        if (e_roa_v) chk("ro_addr_fwd", {bus.ro_dest_x_o, bus.ro_addr_o}, {e_rodest, e_roa});
        chk("ro_data_v", bus.ro_data_v_o, e_rod_v);
        if (e_rod_v) chk("ro_data", bus.ro_data_o, e_rodata);
        chk("rw_data_v", bus.rw_data_v_o, e_rw_v);
        if (e_rw_v) chk("rw_data", bus.rw_data_o, e_rw_d);
        chk("wo_v_o", bus.wo_v_o, fwd_q.size() > 0);
        if (fwd_q.size() > 0)
            chk("wo_beat_o", {bus.wo_dest_x_o, bus.wo_addr_o, bus.wo_data_o},
                {fwd_q[0].dest, fwd_q[0].addr, fwd_q[0].data});

        rd_ro    = mem[bus.ro_addr_i];
        rd_rw    = mem[bus.rw_addr_i];
        e_roa_v  = bus.ro_addr_v_i && !ro_loc;
        e_roa    = bus.ro_addr_i;
        e_rodest = bus.ro_dest_x_i;
        e_rod_v  = st1_v || bus.ro_data_v_i;
        e_rodata = st1_v ? st1_d : bus.ro_data_i;
        st1_v    = ro_loc;
        st1_d    = rd_ro;
        e_rw_v   = yumi && !bus.rw_w_i;
        e_rw_d   = rd_rw;
        if (wo_win) begin
            mem[fifo_q[0].addr] = fifo_q[0].data;
            void'(fifo_q.pop_front());
        end
        if (yumi && bus.rw_w_i) mem[bus.rw_addr_i] = bus.rw_data_i;
        if (fwd_q.size() > 0 && bus.wo_ready_i) void'(fwd_q.pop_front());
        if (bus.wo_v_i && rdy) begin
            nb.addr = bus.wo_addr_i; nb.dest = bus.wo_dest_x_i; nb.data = bus.wo_data_i;
            if (wo_loc) fifo_q.push_back(nb);
            else        fwd_q.push_back(nb);
        end
        starve = (bus.rw_v_i && !yumi) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
        @(negedge clk);
    endtask

    initial begin
        idle();
        bus.wo_ready_i = 1;
        model_clear();
        @(negedge clk);
        repeat (3) step();
        reset = 0;

        // reset state after 5 idle cycles
        repeat (5) step();
        #1;
        chk("rst_ro_addr_v", bus.ro_addr_v_o, 0);
        chk("rst_ro_data_v", bus.ro_data_v_o, 0);
        chk("rst_rw_data_v", bus.rw_data_v_o, 0);
        chk("rst_wo_v", bus.wo_v_o, 0);
        chk("rst_yumi", bus.rw_yumi_o, 0);
        chk("rst_wo_ready", bus.wo_ready_o, 1);
        step();

        // preload words 0..63 through the RW port
        for (int a = 0; a < 64; a++) begin
            bus.rw_v_i = 1; bus.rw_w_i = 1; bus.rw_addr_i = AW'(a); bus.rw_data_i = $urandom;
            step();
        end
        idle();
        step();

        // WO local write then RO local read, 2-cycle read latency
        bus.wo_v_i = 1; bus.wo_dest_x_i = MY_X; bus.wo_addr_i = 10'd5; bus.wo_data_i = 32'hA5;
        step();
        idle();
        repeat (2) step();
        bus.ro_addr_v_i = 1; bus.ro_dest_x_i = MY_X; bus.ro_addr_i = 10'd5;
        step();
        idle();
        #1;
        chk("ro_lat_t1_v", bus.ro_data_v_o, 0);
        chk("ro_lat_t1_fwd", bus.ro_addr_v_o, 0);
        step();
        #1;
        chk("ro_lat_t2_v", bus.ro_data_v_o, 1);
        chk("ro_lat_t2_data", bus.ro_data_o, 32'hA5);
        step();

        // RO forward and RO data pass-through
        bus.ro_addr_v_i = 1; bus.ro_dest_x_i = MY_X + 3'd1; bus.ro_addr_i = 10'd9;
        bus.ro_data_v_i = 1; bus.ro_data_i = 32'h3C;
        step();
        idle();
        #1;
        chk("ro_fwd_v", bus.ro_addr_v_o, 1);
        chk("ro_fwd_addr", {bus.ro_dest_x_o, bus.ro_addr_o}, {MY_X + 3'd1, 10'd9});
        chk("ro_pass_data", {bus.ro_data_v_o, bus.ro_data_o}, {1'b1, 32'h3C});
        step();

        // RO and RW on bank 0 every cycle: RO always wins
        for (int k = 0; k < 12; k++) begin
            bus.ro_addr_v_i = 1; bus.ro_dest_x_i = MY_X; bus.ro_addr_i = 10'd0;
            bus.rw_v_i = 1; bus.rw_w_i = 0; bus.rw_addr_i = 10'd4;
            #1;
            chk("ro_beats_rw_yumi", bus.rw_yumi_o, 0);
            step();
        end
        idle();
        step();

        // mid-operation reset, then WO vs RW on bank 1: starvation guard
        reset = 1;
        repeat (2) step();
        reset = 0;
        bus.wo_v_i = 1; bus.wo_dest_x_i = MY_X; bus.wo_addr_i = 10'd1; bus.wo_data_i = 32'h100;
        step();
        for (int k = 0; k < 11; k++) begin
            bus.wo_v_i = 1; bus.wo_dest_x_i = MY_X; bus.wo_addr_i = 10'd1; bus.wo_data_i = 32'h200 + k;
            bus.rw_v_i = 1; bus.rw_w_i = 0; bus.rw_addr_i = 10'd5;
            #1;
            chk("starve_yumi", bus.rw_yumi_o, k == 8);
`ifdef BSG_GB_TILE_PERF_EN
            if (k == 9) chk("perf_rw_stall", perf_rw, 8);
`endif
            step();
        end
        idle();
        repeat (4) step();

        // forward buffer backpressure and ordering
        bus.wo_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            bus.wo_v_i = 1; bus.wo_dest_x_i = MY_X + 3'd2; bus.wo_addr_i = AW'(k + 20);
            bus.wo_data_i = 32'h11 * (k + 1);
            #1;
            chk("fwd_ready", bus.wo_ready_o, k < 2);
            step();
        end
        idle();
        step();
        bus.wo_ready_i = 1;
        #1;
        chk("fwd_out1", {bus.wo_v_o, bus.wo_data_o}, {1'b1, 32'h11});
        step();
        #1;
        chk("fwd_out2", {bus.wo_v_o, bus.wo_data_o}, {1'b1, 32'h22});
        step();
        #1;
        chk("fwd_empty", bus.wo_v_o, 0);
        step();

        // fill the local FIFO while RO holds the target bank
        for (int k = 0; k < 5; k++) begin
            bus.ro_addr_v_i = 1; bus.ro_dest_x_i = MY_X; bus.ro_addr_i = 10'd2;
            bus.wo_v_i = 1; bus.wo_dest_x_i = MY_X; bus.wo_addr_i = AW'(6 + 4 * k); bus.wo_data_i = $urandom;
            #1;
            chk("fifo_ready", bus.wo_ready_o, k < 4);
            step();
        end
        idle();
        repeat (6) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = (c == 1500 || c == 1501);
            bus.ro_addr_v_i = ($urandom % 3) == 0;
            bus.ro_dest_x_i = ($urandom % 2) ? MY_X : XW'($urandom);
            bus.ro_addr_i   = AW'($urandom % 64);
            bus.ro_data_v_i = !st1_v && (($urandom % 3) == 0);
            bus.ro_data_i   = $urandom;
            bus.wo_v_i      = ($urandom % 2) == 0;
            bus.wo_dest_x_i = ($urandom % 2) ? MY_X : XW'($urandom);
            bus.wo_addr_i   = AW'($urandom % 64);
            bus.wo_data_i   = $urandom;
            bus.wo_ready_i  = ($urandom % 4) != 0;
            bus.rw_v_i      = ($urandom % 2) == 0;
            bus.rw_w_i      = ($urandom % 2) == 0;
            bus.rw_addr_i   = AW'($urandom % 64);
            bus.rw_data_i   = $urandom;
            step();
        end
        reset = 0;
        idle();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
